// File: rtl/cfg_pkg.sv
// Shared definitions for the configuration-chain loader: FSM encoding and the bit-serial CRC-16 step.
// The VERIFY states are present only when CONFIG_READBACK_EN is defined.
package cfg_pkg;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
`ifdef CONFIG_READBACK_EN
    ST_VERIFY_LO,
    ST_VERIFY_HI,
`endif
    ST_FIN
  } state_e;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    crc16_step = {crc[14:0], 1'b0} ^ ((crc[15] ^ bit_in) ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/prog_clk_gen.sv
// Programming-clock phase generator: counts CLK_DIV cycles per half-period and
// toggles a registered prog_clk level at each phase end while the chain is being clocked.
module prog_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic hi_phase,
  output logic phase_end,
  output logic prog_clk
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          prog_clk_q;

  assign phase_end = run && (cnt_q == CW'(CLK_DIV - 1));
  assign prog_clk  = prog_clk_q;

  // The level flips on the same edge the FSM changes phase, so prog_clk never glitches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      prog_clk_q <= 1'b0;
    end else if (!run) begin
      cnt_q      <= '0;
      prog_clk_q <= 1'b0;
    end else if (phase_end) begin
      cnt_q      <= '0;
      prog_clk_q <= ~hi_phase;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/config_loader.sv
// Serialises a valid/ready bitstream word stream (LSB first) into the daisy-chained programming registers.
// Defining CONFIG_READBACK_EN adds a CRC-16 checked, non-destructive readback rotation of the chain.
module config_loader
  import cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 304,
  parameter int WORD_W    = 8,
  parameter int CLK_DIV   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              prog_clk,
  output logic              prog_en,
  output logic              prog_in,
  input  logic              prog_out
);
  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int WW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  state_e            state_q;
  logic [BW-1:0]     bit_cnt_q;
  logic [WW-1:0]     wbit_q;
  logic [WORD_W-1:0] shreg_q;
  logic              busy_q, done_q, s_ready_q, prog_en_q, prog_in_q;
  logic              clk_run, clk_hi, phase_end, handshake, last_bit, word_end, next_bit;

  assign handshake = (state_q == ST_FETCH) && s_valid;
  assign last_bit  = (bit_cnt_q == BW'(CHAIN_LEN - 1));
  assign word_end  = (wbit_q == WW'(WORD_W - 1));
  assign next_bit  = (state_q == ST_SHIFT_HI) && phase_end && !last_bit && !word_end;

`ifdef CONFIG_READBACK_EN
  logic        error_q;
  logic [15:0] crc_ld_q, crc_rd_q;
  assign clk_run = state_q inside {ST_SHIFT_LO, ST_SHIFT_HI, ST_VERIFY_LO, ST_VERIFY_HI};
  assign clk_hi  = state_q inside {ST_SHIFT_HI, ST_VERIFY_HI};
  assign error   = error_q;
`else
  logic unused_prog_out;
  assign unused_prog_out = prog_out;
  assign clk_run = state_q inside {ST_SHIFT_LO, ST_SHIFT_HI};
  assign clk_hi  = (state_q == ST_SHIFT_HI);
  assign error   = 1'b0;
`endif

  prog_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (clk_run),
    .hi_phase (clk_hi),
    .phase_end(phase_end),
    .prog_clk (prog_clk)
  );

  // Word shifter holds the not-yet-sent bits; bit 0 of the fetched word goes straight to prog_in.
  always_ff @(posedge clk) begin
    if (handshake) shreg_q <= s_data >> 1;
    else if (next_bit) shreg_q <= shreg_q >> 1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      wbit_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      s_ready_q <= 1'b0;
      prog_en_q <= 1'b0;
      prog_in_q <= 1'b0;
`ifdef CONFIG_READBACK_EN
      error_q   <= 1'b0;
      crc_ld_q  <= CRC16_INIT;
      crc_rd_q  <= CRC16_INIT;
`endif
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          state_q   <= ST_FETCH;
          busy_q    <= 1'b1;
          done_q    <= 1'b0;
          s_ready_q <= 1'b1;
          bit_cnt_q <= '0;
          wbit_q    <= '0;
`ifdef CONFIG_READBACK_EN
          error_q   <= 1'b0;
          crc_ld_q  <= CRC16_INIT;
          crc_rd_q  <= CRC16_INIT;
`endif
        end
        ST_FETCH: if (s_valid) begin
          state_q   <= ST_SHIFT_LO;
          s_ready_q <= 1'b0;
          prog_en_q <= 1'b1;
          prog_in_q <= s_data[0];
          wbit_q    <= '0;
        end
        ST_SHIFT_LO: if (phase_end) state_q <= ST_SHIFT_HI;
        ST_SHIFT_HI: if (phase_end) begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
`ifdef CONFIG_READBACK_EN
          crc_ld_q  <= crc16_step(crc_ld_q, prog_in_q);
`endif
          if (last_bit) begin
`ifdef CONFIG_READBACK_EN
            // Tail is already stable here; feeding it back makes the rotation non-destructive.
            state_q   <= ST_VERIFY_LO;
            bit_cnt_q <= '0;
            prog_in_q <= prog_out;
`else
            state_q   <= ST_FIN;
            prog_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
`endif
          end else if (word_end) begin
            state_q   <= ST_FETCH;
            s_ready_q <= 1'b1;
          end else begin
            state_q   <= ST_SHIFT_LO;
            wbit_q    <= wbit_q + 1'b1;
            prog_in_q <= shreg_q[0];
          end
        end
`ifdef CONFIG_READBACK_EN
        ST_VERIFY_LO: if (phase_end) begin
          state_q  <= ST_VERIFY_HI;
          crc_rd_q <= crc16_step(crc_rd_q, prog_out);
        end
        ST_VERIFY_HI: if (phase_end) begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (last_bit) begin
            state_q   <= ST_FIN;
            prog_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= (crc_rd_q == crc_ld_q);
            error_q   <= (crc_rd_q != crc_ld_q);
          end else begin
            state_q   <= ST_VERIFY_LO;
            prog_in_q <= prog_out;
          end
        end
`endif
        ST_FIN:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign s_ready = s_ready_q;
  assign prog_en = prog_en_q;
  assign prog_in = prog_in_q;

endmodule
